// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative shift-add multiply sequencer for the execute stage.
// Accepts a MUL request, stalls the pipeline for WIDTH iterations plus one
// result cycle, and returns a full 2*WIDTH product (signed or unsigned).
module mul_seq_ctrl #(
  parameter int          WIDTH    = 32,
  parameter logic [3:0]  MUL_CODE = 4'd3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic [WIDTH-1:0] result_hi_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_neg;

  logic               w_accept;
  logic               w_lastIter;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_accStep;
  logic [2*WIDTH-1:0] w_product;

  // Accept decode, operand magnitudes and one shift-add step of the accumulator
  always_comb begin
    w_accept   = (r_state == S_IDLE) && start_i && (ALUCtrl_i == MUL_CODE);
    w_lastIter = (r_count == CW'(WIDTH - 1));
    w_mag1     = (signed_i && src1_i[WIDTH-1]) ? (~src1_i + WIDTH'(1)) : src1_i;
    w_mag2     = (signed_i && src2_i[WIDTH-1]) ? (~src2_i + WIDTH'(1)) : src2_i;
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                 (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    w_accStep  = {w_sum, r_acc[WIDTH-1:1]};
    w_product  = r_neg ? (~w_accStep + (2*WIDTH)'(1)) : w_accStep;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic and state-decoded status outputs
  always_comb begin
    w_stateNext = r_state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        busy_o = 1'b1;
        if (w_lastIter) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        busy_o      = 1'b1;
        done_o      = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Operand latching, iteration datapath and result register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count     <= '0;
      r_acc       <= '0;
      r_mplier    <= '0;
      r_mcand     <= '0;
      r_neg       <= 1'b0;
      result_lo_o <= '0;
      result_hi_o <= '0;
    end else if (w_accept) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= w_mag1;
      r_mplier <= w_mag2;
      r_neg    <= signed_i & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
    end else if (r_state == S_RUN) begin
      r_acc    <= w_accStep;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
      if (w_lastIter) begin
        result_hi_o <= w_product[2*WIDTH-1:WIDTH];
        result_lo_o <= w_product[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed scenarios with literal products plus a long
// randomized run, all outputs compared every cycle against a behavioural model.
module tb_mul_seq_ctrl;

  localparam int WIDTH = 32;

  logic              clk_i;
  logic              rst_i;
  logic              start_i;
  logic [3:0]        ALUCtrl_i;
  logic              signed_i;
  logic [WIDTH-1:0]  src1_i;
  logic [WIDTH-1:0]  src2_i;
  logic              busy_o;
  logic              done_o;
  logic [WIDTH-1:0]  result_lo_o;
  logic [WIDTH-1:0]  result_hi_o;

  int checkCount = 0;
  int errorCount = 0;

  // Model state: cycles of busy left, pending and visible product
  int          mRemain  = 0;
  logic [63:0] mPending = '0;
  logic [63:0] mResult  = '0;
  bit          mValid   = 0;

  mul_seq_ctrl #(.WIDTH(WIDTH), .MUL_CODE(4'd3)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .ALUCtrl_i   (ALUCtrl_i),
    .signed_i    (signed_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_lo_o (result_lo_o),
    .result_hi_o (result_hi_o)
  );

  // Free-running clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Overall time limit
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] refProduct(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint unsigned ua;
    longint unsigned ub;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [3:0] code, input logic sg,
                               input logic [31:0] a, input logic [31:0] b);
    start_i   = st;
    ALUCtrl_i = code;
    signed_i  = sg;
    src1_i    = a;
    src2_i    = b;
  endtask

  task automatic stepCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Behavioural model: a request occupies WIDTH+1 busy cycles, the last one is the done cycle
  always @(posedge clk_i) begin
    if (rst_i) begin
      mRemain = 0;
      mResult = '0;
      mValid  = 1;
    end else if (mRemain == 0) begin
      if (start_i && ALUCtrl_i == 4'd3) begin
        mRemain  = WIDTH + 1;
        mPending = refProduct(signed_i, src1_i, src2_i);
      end
    end else begin
      mRemain = mRemain - 1;
      if (mRemain == 1) begin
        mResult = mPending;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk_i) begin
    if (mValid) begin
      checkOutput("busy", 64'(busy_o), 64'(mRemain > 0));
      checkOutput("done", 64'(done_o), 64'(mRemain == 1));
      checkOutput("result_hi", 64'(result_hi_o), 64'(mResult[63:32]));
      checkOutput("result_lo", 64'(result_lo_o), 64'(mResult[31:0]));
    end
  end

  // Start one multiply, scramble operands after accept, wait for done and check literals
  task automatic runDirected(input string name, input logic sg, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
    int n;
    applyStimulus(1'b1, 4'd3, sg, a, b);
    stepCycle();
    applyStimulus(1'b0, 4'd3, ~sg, ~a, b ^ 32'h5A5A_5A5A);
    n = 1;
    checkOutput({name, " busy@1"}, 64'(busy_o), 64'd1);
    while (!done_o && n < 40) begin
      stepCycle();
      n++;
    end
    checkOutput({name, " latency"}, 64'(n), 64'd33);
    checkOutput({name, " hi"}, 64'(result_hi_o), 64'(expHi));
    checkOutput({name, " lo"}, 64'(result_lo_o), 64'(expLo));
    stepCycle();
    checkOutput({name, " idle"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int n;
    int doneAt[$];
    applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    rst_i = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("reset busy", 64'(busy_o), 64'd0);
    checkOutput("reset done", 64'(done_o), 64'd0);
    checkOutput("reset lo", 64'(result_lo_o), 64'd0);
    rst_i = 1'b0;
    stepCycle();

    $display("[TB] directed products");
    runDirected("u 7*6", 1'b0, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A);
    runDirected("s -3*5", 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runDirected("s min*-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    runDirected("u max*max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    runDirected("u zero", 1'b0, 32'd0, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000);
    runDirected("s -1*-1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);

    $display("[TB] ignored starts");
    applyStimulus(1'b1, 4'd2, 1'b0, 32'd5, 32'd5);
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("add code busy", 64'(busy_o), 64'd0);
    end
    checkOutput("add code lo kept", 64'(result_lo_o), 64'd1);
    applyStimulus(1'b1, 4'd3, 1'b0, 32'd100, 32'd3);
    stepCycle();
    applyStimulus(1'b0, 4'd3, 1'b0, 32'd0, 32'd0);
    n = 1;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      n++;
    end
    applyStimulus(1'b1, 4'd3, 1'b0, 32'd77, 32'd88);
    stepCycle();
    n++;
    applyStimulus(1'b0, 4'd3, 1'b0, 32'd0, 32'd0);
    while (!done_o && n < 40) begin
      stepCycle();
      n++;
    end
    checkOutput("run start latency", 64'(n), 64'd33);
    applyStimulus(1'b1, 4'd3, 1'b1, 32'hFFFF_FFFF, 32'd99);
    stepCycle();
    applyStimulus(1'b0, 4'd3, 1'b0, 32'd0, 32'd0);
    checkOutput("done start busy", 64'(busy_o), 64'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) n++;
      stepCycle();
    end
    checkOutput("no second op", 64'(n), 64'd0);
    checkOutput("first result lo", 64'(result_lo_o), 64'd300);

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 4'd3, 1'b0, 32'h1234, 32'h10);
    stepCycle();
    applyStimulus(1'b0, 4'd3, 1'b0, 32'd0, 32'd0);
    for (int i = 1; i < 10; i++) stepCycle();
    rst_i = 1'b1;
    stepCycle();
    rst_i = 1'b0;
    checkOutput("abort busy", 64'(busy_o), 64'd0);
    checkOutput("abort done", 64'(done_o), 64'd0);
    checkOutput("abort hi", 64'(result_hi_o), 64'd0);
    checkOutput("abort lo", 64'(result_lo_o), 64'd0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_o) n++;
      stepCycle();
    end
    checkOutput("abort no done", 64'(n), 64'd0);
    runDirected("u 9*9", 1'b0, 32'd9, 32'd9, 32'h0000_0000, 32'h0000_0051);

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 4'd3, 1'b0, 32'd1000, 32'd1000);
    for (int c = 1; c <= 70; c++) begin
      stepCycle();
      if (done_o) doneAt.push_back(c);
    end
    applyStimulus(1'b0, 4'd3, 1'b0, 32'd0, 32'd0);
    checkOutput("b2b pulses", 64'(doneAt.size()), 64'd2);
    if (doneAt.size() == 2) begin
      checkOutput("b2b first", 64'(doneAt[0]), 64'd33);
      checkOutput("b2b second", 64'(doneAt[1]), 64'd67);
    end
    checkOutput("b2b lo", 64'(result_lo_o), 64'd1000000);
    for (int i = 0; i < 40; i++) stepCycle();

    $display("[TB] randomized run");
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: a = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      applyStimulus($urandom_range(0, 3) == 0, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd3,
                    1'($urandom_range(0, 1)), a, b);
      rst_i = ($urandom_range(0, 599) == 0);
      stepCycle();
    end
    rst_i = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 40; i++) stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
